// File: rtl/program_loader.sv
// Writer side of the CPU program RAM: parses SYNC/LEN/DATA/CHK frames, writes data bytes into RAM
// and keeps the CPU halted until a frame with a good checksum has been loaded.
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ADDR_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_cpu_halt,
  output logic              o_load_done,
  output logic              o_load_error
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e r_state, w_state_next;

  // One extra bit so a full-depth length (DEPTH) is representable.
  logic [ADDR_W:0]   r_cnt, w_cnt_next;
  logic [ADDR_W:0]   r_len, w_len_next;
  logic [7:0]        r_sum, w_sum_next;
  logic              r_in_ready, w_in_ready_next;
  logic              r_cpu_halt, w_cpu_halt_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              w_accept;
  logic              w_len_ok;

  assign w_accept = i_in_valid && r_in_ready;
  assign w_len_ok = (i_in_data != 8'd0) && (32'(i_in_data) <= DEPTH);

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_len_next      = r_len;
    w_sum_next      = r_sum;
    w_cpu_halt_next = r_cpu_halt;
    w_mem_we_next   = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept && (i_in_data == SYNC_BYTE)) begin
          w_state_next    = StLen;
          w_cpu_halt_next = 1'b1;
        end
      end
      StLen: begin
        if (w_accept) begin
          if (w_len_ok) begin
            w_len_next   = i_in_data[ADDR_W:0];
            w_cnt_next   = '0;
            w_sum_next   = 8'd0;
            w_state_next = StData;
          end else begin
            w_state_next = StErr;
          end
        end
      end
      StData: begin
        // SYNC_BYTE is plain payload here; no resynchronisation mid-frame.
        if (w_accept) begin
          w_mem_we_next = 1'b1;
          w_sum_next    = r_sum + i_in_data;
          w_cnt_next    = r_cnt + 1'b1;
          if ((r_cnt + 1'b1) == r_len) begin
            w_state_next = StChk;
          end
        end
      end
      StChk: begin
        if (w_accept) begin
          if (i_in_data == r_sum) begin
            w_state_next    = StDone;
            w_cpu_halt_next = 1'b0;
          end else begin
            w_state_next = StErr;
          end
        end
      end
      StDone:  w_state_next = StIdle;
      StErr:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    w_in_ready_next = (w_state_next != StDone) && (w_state_next != StErr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_len       <= '0;
      r_sum       <= 8'd0;
      r_in_ready  <= 1'b0;
      r_cpu_halt  <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_len      <= w_len_next;
      r_sum      <= w_sum_next;
      r_in_ready <= w_in_ready_next;
      r_cpu_halt <= w_cpu_halt_next;
      r_mem_we   <= w_mem_we_next;
      if (w_mem_we_next) begin
        r_mem_addr  <= r_cnt[ADDR_W-1:0];
        r_mem_wdata <= i_in_data;
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_cpu_halt   = r_cpu_halt;
  assign o_load_done  = (r_state == StDone);
  assign o_load_error = (r_state == StErr);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives framed byte streams, checks writes, pulses and halt.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       o_in_ready, o_mem_we, o_cpu_halt, o_load_done, o_load_error;
  logic [3:0] o_mem_addr;
  logic [7:0] o_mem_wdata;

  int checks = 0;
  int errors = 0;
  int n_we = 0;
  int n_done = 0;
  int n_err = 0;
  int we0, done0, err0;

  // Data bytes sum to 0x101, so the good checksum is 0x01.
  logic [7:0] frame_a [6] = '{8'h15, 8'h30, 8'h25, 8'h55, 8'h41, 8'h01};
  logic [7:0] frame_r [3] = '{8'h11, 8'h22, 8'h33};

  program_loader #(
    .SYNC_BYTE(8'hA5),
    .DEPTH    (16),
    .ADDR_W   (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (o_in_ready),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_cpu_halt  (o_cpu_halt),
    .o_load_done (o_load_done),
    .o_load_error(o_load_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_mem_we === 1'b1) n_we++;
    if (o_load_done === 1'b1) n_done++;
    if (o_load_error === 1'b1) n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a byte, wait (bounded) for ready, then check the write one cycle after acceptance.
  task automatic send_byte(input logic [7:0] b, input logic exp_we, input logic [3:0] exp_addr,
                           input int gap);
    int waits;
    waits = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (o_in_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("in_ready_before_accept", o_in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mem_we", o_mem_we, exp_we);
    if (exp_we) begin
      chk("mem_addr", o_mem_addr, exp_addr);
      chk("mem_wdata", o_mem_wdata, b);
    end
  endtask

  initial begin
    // Reset values
    rst = 1'b1;
    idle(2);
    chk("rst_in_ready", o_in_ready, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);
    chk("rst_cpu_halt", o_cpu_halt, 1);
    chk("rst_load_done", o_load_done, 0);
    chk("rst_load_error", o_load_error, 0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_in_ready", o_in_ready, 1);
    chk("post_rst_cpu_halt", o_cpu_halt, 1);

    // Good 6-byte frame
    we0 = n_we; done0 = n_done; err0 = n_err;
    send_byte(8'hA5, 1'b0, 4'd0, 0);
    chk("a_halt_after_sync", o_cpu_halt, 1);
    send_byte(8'h06, 1'b0, 4'd0, 0);
    for (int i = 0; i < 6; i++) send_byte(frame_a[i], 1'b1, 4'(i), 0);
    send_byte(8'h01, 1'b0, 4'd0, 0);
    chk("a_load_done", o_load_done, 1);
    chk("a_load_error", o_load_error, 0);
    chk("a_cpu_halt", o_cpu_halt, 0);
    chk("a_ready_in_done", o_in_ready, 0);
    idle(1);
    chk("a_done_one_cycle", o_load_done, 0);
    chk("a_ready_back", o_in_ready, 1);
    chk("a_halt_stays_low", o_cpu_halt, 0);
    idle(2);
    chk("a_write_count", n_we - we0, 6);
    chk("a_done_count", n_done - done0, 1);
    chk("a_err_count", n_err - err0, 0);

    // Same frame, bad checksum
    we0 = n_we; done0 = n_done; err0 = n_err;
    send_byte(8'hA5, 1'b0, 4'd0, 0);
    send_byte(8'h06, 1'b0, 4'd0, 0);
    for (int i = 0; i < 6; i++) send_byte(frame_a[i], 1'b1, 4'(i), 0);
    send_byte(8'h00, 1'b0, 4'd0, 0);
    chk("b_load_error", o_load_error, 1);
    chk("b_load_done", o_load_done, 0);
    chk("b_cpu_halt", o_cpu_halt, 1);
    idle(2);
    chk("b_write_count", n_we - we0, 6);
    chk("b_done_count", n_done - done0, 0);
    chk("b_err_count", n_err - err0, 1);

    // Illegal lengths 0 and DEPTH+1
    we0 = n_we; err0 = n_err;
    send_byte(8'hA5, 1'b0, 4'd0, 0);
    send_byte(8'h00, 1'b0, 4'd0, 0);
    chk("len0_error", o_load_error, 1);
    send_byte(8'hA5, 1'b0, 4'd0, 0);
    send_byte(8'h11, 1'b0, 4'd0, 0);
    chk("len17_error", o_load_error, 1);
    idle(2);
    chk("badlen_write_count", n_we - we0, 0);
    chk("badlen_err_count", n_err - err0, 2);
    chk("badlen_halt", o_cpu_halt, 1);

    // Garbage dropped, then 1-byte frame whose payload equals SYNC_BYTE
    we0 = n_we; done0 = n_done; err0 = n_err;
    send_byte(8'h00, 1'b0, 4'd0, 0);
    send_byte(8'hFF, 1'b0, 4'd0, 0);
    send_byte(8'hA4, 1'b0, 4'd0, 0);
    send_byte(8'hA5, 1'b0, 4'd0, 0);
    send_byte(8'h01, 1'b0, 4'd0, 0);
    send_byte(8'hA5, 1'b1, 4'd0, 0);
    send_byte(8'hA5, 1'b0, 4'd0, 0);
    chk("g_load_done", o_load_done, 1);
    chk("g_cpu_halt", o_cpu_halt, 0);
    idle(2);
    chk("g_write_count", n_we - we0, 1);
    chk("g_err_count", n_err - err0, 0);

    // Non-sync byte in IDLE leaves the CPU running
    send_byte(8'h3C, 1'b0, 4'd0, 0);
    chk("idle_garbage_halt", o_cpu_halt, 0);

    // Random gaps, reset after the third data byte
    we0 = n_we; done0 = n_done; err0 = n_err;
    send_byte(8'hA5, 1'b0, 4'd0, $urandom_range(0, 3));
    chk("r_halt_after_sync", o_cpu_halt, 1);
    send_byte(8'h06, 1'b0, 4'd0, $urandom_range(0, 3));
    for (int i = 0; i < 3; i++) send_byte(frame_r[i], 1'b1, 4'(i), $urandom_range(0, 3));
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    idle(1);
    chk("r_no_write_in_reset", o_mem_we, 0);
    chk("r_ready_in_reset", o_in_ready, 0);
    chk("r_halt_in_reset", o_cpu_halt, 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    idle(1);
    chk("r_ready_after_reset", o_in_ready, 1);
    send_byte(8'h06, 1'b0, 4'd0, 0);
    idle(2);
    chk("r_write_count", n_we - we0, 3);
    chk("r_done_count", n_done - done0, 0);
    chk("r_err_count", n_err - err0, 0);
    chk("r_halt_final", o_cpu_halt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
